register_bank_manager: RTL and testbench

Parametrised dual-bank (integer / float) register manager for the 2nd-generation core. It accepts register writes from NUM_WRITE execution units through per-port FIFOs with valid/ready back-pressure, and commits one write per cycle under round-robin arbitration. It serves two registered read ports with same-edge commit bypass and a per-read `pending` flag, so the issue stage can stall on any queued write.

---
 rtl/register_bank_manager_if.sv | 42 ++++
 rtl/register_bank_manager.sv | 228 ++++++++++++++++++++++
 tb/tb_register_bank_manager.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/register_bank_manager_if.sv
// Bus bundle for register_bank_manager: write-port FIFOs, two read ports and the commit report.
// The master modport is the issue/execute side; the slave modport is the register manager.
interface register_bank_manager_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_WRITE  = 4
);
    logic [NUM_WRITE-1:0]            wr_valid;
    logic [NUM_WRITE-1:0]            wr_ready;
    logic [NUM_WRITE*ADDR_WIDTH-1:0] wr_addr;
    logic [NUM_WRITE-1:0]            wr_float;
    logic [NUM_WRITE*DATA_WIDTH-1:0] wr_data;

    logic [ADDR_WIDTH-1:0]           rs_addr;
    logic                            rs_float;
    logic [DATA_WIDTH-1:0]           rs_data;
    logic                            rs_pending;
    logic [ADDR_WIDTH-1:0]           rt_addr;
    logic                            rt_float;
    logic [DATA_WIDTH-1:0]           rt_data;
    logic                            rt_pending;

    logic                            commit_valid;
    logic [2:0]                      commit_port;
    logic                            commit_float;
    logic [ADDR_WIDTH-1:0]           commit_addr;
    logic [DATA_WIDTH-1:0]           commit_data;

    modport master (
        output wr_valid, wr_addr, wr_float, wr_data,
        output rs_addr, rs_float, rt_addr, rt_float,
        input  wr_ready, rs_data, rs_pending, rt_data, rt_pending,
        input  commit_valid, commit_port, commit_float, commit_addr, commit_data
    );

    modport slave (
        input  wr_valid, wr_addr, wr_float, wr_data,
        input  rs_addr, rs_float, rt_addr, rt_float,
        output wr_ready, rs_data, rs_pending, rt_data, rt_pending,
        output commit_valid, commit_port, commit_float, commit_addr, commit_data
    );
endinterface

// File: rtl/register_bank_manager.sv
// Dual-bank (int/float) register manager: per-port write FIFOs, round-robin single commit per cycle,
// two registered read ports with commit bypass and pending flags. Option macro: REGMGR_ZERO_REG_EN.
module register_bank_manager #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_WRITE  = 4,
    parameter int DEPTH      = 2
) (
    input logic                     clk,
    input logic                     reset,
    register_bank_manager_if.slave  bus
);
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int GW   = (NUM_WRITE > 1) ? $clog2(NUM_WRITE) : 1;
    localparam int NREG = 1 << ADDR_WIDTH;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [GW-1:0] GNT_ONE = GW'(1);
    localparam logic [GW-1:0] GNT_MAX = GW'(NUM_WRITE - 1);

    logic [ADDR_WIDTH-1:0] fifo_addr_r  [NUM_WRITE][DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_r  [NUM_WRITE][DEPTH];
    logic [DEPTH-1:0]      fifo_float_r [NUM_WRITE];
    logic [DEPTH-1:0]      fifo_vld_r   [NUM_WRITE];
    logic [PW-1:0]         wr_ptr_r     [NUM_WRITE];
    logic [PW-1:0]         rd_ptr_r     [NUM_WRITE];
    logic [GW-1:0]         rr_ptr_r;
    logic [DATA_WIDTH-1:0] int_bank_r   [NREG];
    logic [DATA_WIDTH-1:0] flt_bank_r   [NREG];
    logic [DATA_WIDTH-1:0] rs_data_r, rt_data_r;
    logic                  rs_pend_r, rt_pend_r;

    logic [NUM_WRITE-1:0]  full_s, empty_s, ready_s, push_s, pop_s;
    logic                  any_s;
    logic [GW-1:0]         grant_s;
    int                    idx_s;
    logic [GW-1:0]         cand_s;
    logic                  commit_float_s;
    logic [ADDR_WIDTH-1:0] commit_addr_s;
    logic [DATA_WIDTH-1:0] commit_data_s;
    logic                  bank_we_s;
    logic [DATA_WIDTH-1:0] rs_rdata_s, rt_rdata_s;
    logic                  rs_pend_s, rt_pend_s;

    // FIFO occupancy, ready and accepted pushes
    always_comb begin
        full_s  = '0;
        empty_s = '0;
        ready_s = '0;
        push_s  = '0;
        for (int p = 0; p < NUM_WRITE; p++) begin
            full_s[p]  = fifo_vld_r[p][wr_ptr_r[p]];
            empty_s[p] = ~fifo_vld_r[p][rd_ptr_r[p]];
            ready_s[p] = ~full_s[p] & reset;
            push_s[p]  = bus.wr_valid[p] & ready_s[p];
        end
    end

    // Round-robin grant: first non-empty FIFO at or after the pointer
    always_comb begin
        grant_s = '0;
        any_s   = 1'b0;
        idx_s   = 0;
        cand_s  = '0;
        for (int k = 0; k < NUM_WRITE; k++) begin
            idx_s = int'(rr_ptr_r) + k;
            if (idx_s >= NUM_WRITE) begin
                idx_s = idx_s - NUM_WRITE;
            end else begin
                idx_s = idx_s;
            end
            cand_s = GW'(idx_s);
            if (!any_s && !empty_s[cand_s]) begin
                any_s   = 1'b1;
                grant_s = cand_s;
            end else begin
                any_s = any_s;
            end
        end
    end

    // Selected head, pop vector and bank write enable
    always_comb begin
        pop_s = '0;
        for (int p = 0; p < NUM_WRITE; p++) begin
            pop_s[p] = any_s & (grant_s == GW'(p));
        end
        if (any_s) begin
            commit_float_s = fifo_float_r[grant_s][rd_ptr_r[grant_s]];
            commit_addr_s  = fifo_addr_r[grant_s][rd_ptr_r[grant_s]];
            commit_data_s  = fifo_data_r[grant_s][rd_ptr_r[grant_s]];
        end else begin
            commit_float_s = 1'b0;
            commit_addr_s  = '0;
            commit_data_s  = '0;
        end
`ifdef REGMGR_ZERO_REG_EN
        // int r0 still pops and reports, it just never lands in the bank
        bank_we_s = any_s & ~(~commit_float_s & (commit_addr_s == '0));
`else
        bank_we_s = any_s;
`endif
    end

    // Read data with commit bypass, and pending from post-edge FIFO contents
    always_comb begin : read_calc
        logic                  nv;
        logic                  slot_new;
        logic                  nf;
        logic [ADDR_WIDTH-1:0] na;
        nv = 1'b0;
        slot_new = 1'b0;
        nf = 1'b0;
        na = '0;
        rs_pend_s = 1'b0;
        rt_pend_s = 1'b0;
        for (int p = 0; p < NUM_WRITE; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_new = push_s[p] & (wr_ptr_r[p] == PW'(i));
                nv = (fifo_vld_r[p][i] & ~(pop_s[p] & (rd_ptr_r[p] == PW'(i)))) | slot_new;
                na = slot_new ? bus.wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH] : fifo_addr_r[p][i];
                nf = slot_new ? bus.wr_float[p] : fifo_float_r[p][i];
                rs_pend_s = rs_pend_s | (nv & (nf == bus.rs_float) & (na == bus.rs_addr));
                rt_pend_s = rt_pend_s | (nv & (nf == bus.rt_float) & (na == bus.rt_addr));
            end
        end
        if (any_s && (commit_float_s == bus.rs_float) && (commit_addr_s == bus.rs_addr)) begin
            rs_rdata_s = commit_data_s;
        end else begin
            rs_rdata_s = bus.rs_float ? flt_bank_r[bus.rs_addr] : int_bank_r[bus.rs_addr];
        end
        if (any_s && (commit_float_s == bus.rt_float) && (commit_addr_s == bus.rt_addr)) begin
            rt_rdata_s = commit_data_s;
        end else begin
            rt_rdata_s = bus.rt_float ? flt_bank_r[bus.rt_addr] : int_bank_r[bus.rt_addr];
        end
`ifdef REGMGR_ZERO_REG_EN
        if (!bus.rs_float && (bus.rs_addr == '0)) begin
            rs_rdata_s = '0;
            rs_pend_s  = 1'b0;
        end else begin
            rs_rdata_s = rs_rdata_s;
        end
        if (!bus.rt_float && (bus.rt_addr == '0)) begin
            rt_rdata_s = '0;
            rt_pend_s  = 1'b0;
        end else begin
            rt_rdata_s = rt_rdata_s;
        end
`endif
    end

    // FIFO storage, pointers and arbiter pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < NUM_WRITE; p++) begin
                fifo_vld_r[p]   <= '0;
                fifo_float_r[p] <= '0;
                wr_ptr_r[p]     <= '0;
                rd_ptr_r[p]     <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    fifo_addr_r[p][i] <= '0;
                    fifo_data_r[p][i] <= '0;
                end
            end
            rr_ptr_r <= '0;
        end else begin
            for (int p = 0; p < NUM_WRITE; p++) begin
                if (push_s[p]) begin
                    fifo_addr_r[p][wr_ptr_r[p]]  <= bus.wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
                    fifo_data_r[p][wr_ptr_r[p]]  <= bus.wr_data[p*DATA_WIDTH +: DATA_WIDTH];
                    fifo_float_r[p][wr_ptr_r[p]] <= bus.wr_float[p];
                    fifo_vld_r[p][wr_ptr_r[p]]   <= 1'b1;
                    wr_ptr_r[p]                  <= wr_ptr_r[p] + PTR_ONE;
                end
                // push and pop never share a slot: a full FIFO refuses pushes
                if (pop_s[p]) begin
                    fifo_vld_r[p][rd_ptr_r[p]] <= 1'b0;
                    rd_ptr_r[p]                <= rd_ptr_r[p] + PTR_ONE;
                end
            end
            if (any_s) begin
                rr_ptr_r <= (grant_s == GNT_MAX) ? '0 : grant_s + GNT_ONE;
            end
        end
    end

    // Register banks
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREG; r++) begin
                int_bank_r[r] <= '0;
                flt_bank_r[r] <= '0;
            end
        end else if (bank_we_s) begin
            if (commit_float_s) begin
                flt_bank_r[commit_addr_s] <= commit_data_s;
            end else begin
                int_bank_r[commit_addr_s] <= commit_data_s;
            end
        end
    end

    // Registered read ports
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rs_data_r <= '0;
            rt_data_r <= '0;
            rs_pend_r <= 1'b0;
            rt_pend_r <= 1'b0;
        end else begin
            rs_data_r <= rs_rdata_s;
            rt_data_r <= rt_rdata_s;
            rs_pend_r <= rs_pend_s;
            rt_pend_r <= rt_pend_s;
        end
    end

    assign bus.wr_ready     = ready_s;
    assign bus.rs_data      = rs_data_r;
    assign bus.rt_data      = rt_data_r;
    assign bus.rs_pending   = rs_pend_r;
    assign bus.rt_pending   = rt_pend_r;
    assign bus.commit_valid = any_s;
    assign bus.commit_port  = 3'(grant_s);
    assign bus.commit_float = commit_float_s;
    assign bus.commit_addr  = commit_addr_s;
    assign bus.commit_data  = commit_data_s;
endmodule

// File: tb/tb_register_bank_manager.sv
// Directed bench for register_bank_manager: reset, bypass, bank separation, round-robin,
// back-pressure and int r0 handling (both REGMGR_ZERO_REG_EN settings).
module tb_register_bank_manager;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NW = 4;
    localparam int DP = 2;
`ifdef REGMGR_ZERO_REG_EN
    localparam logic ZR = 1'b1;
`else
    localparam logic ZR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    register_bank_manager_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WRITE(NW)) bus ();
    register_bank_manager #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WRITE(NW), .DEPTH(DP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input int p, input logic v, input logic fl,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.wr_valid[p]          = v;
        bus.wr_float[p]          = fl;
        bus.wr_addr[p*AW +: AW]  = a;
        bus.wr_data[p*DW +: DW]  = d;
    endtask

    task automatic clear_wr();
        bus.wr_valid = '0;
        bus.wr_float = '0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
    endtask

    task automatic set_rd(input logic sf, input logic [AW-1:0] sa, input logic tf, input logic [AW-1:0] ta);
        bus.rs_float = sf;
        bus.rs_addr  = sa;
        bus.rt_float = tf;
        bus.rt_addr  = ta;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NW-1:0] rdy;
        logic [NW-1:0] val;
        logic [DW-1:0] p2_log[$];
        logic [DW-1:0] p2_exp[3];
        logic          bp_seen;
        int            k2, pushes, commits, cyc;

        clear_wr();
        set_rd(1'b0, 5'd0, 1'b0, 5'd0);
        #2 reset = 1'b0;
        repeat (2) tick();
        chk("rst_wr_ready", bus.wr_ready, 4'h0);
        chk("rst_commit_valid", bus.commit_valid, 1'b0);
        chk("rst_commit_port", bus.commit_port, 3'd0);
        chk("rst_commit_data", bus.commit_data, 32'h0);
        chk("rst_rs_data", bus.rs_data, 32'h0);
        chk("rst_rs_pending", bus.rs_pending, 1'b0);
        chk("rst_rt_pending", bus.rt_pending, 1'b0);
        reset = 1'b1;
        #1;
        chk("rel_wr_ready", bus.wr_ready, 4'hF);

        // reset in the middle of a drain on port 0
        set_rd(1'b0, 5'd1, 1'b0, 5'd3);
        set_wr(0, 1'b1, 1'b0, 5'd1, 32'h11);
        tick();
        chk("md_commit_addr1", bus.commit_addr, 5'd1);
        chk("md_commit_valid", bus.commit_valid, 1'b1);
        chk("md_rs_pend_r1", bus.rs_pending, 1'b1);
        set_wr(0, 1'b1, 1'b0, 5'd3, 32'h33);
        tick();
        chk("md_bypass_r1", bus.rs_data, 32'h11);
        chk("md_rs_pend_r1_done", bus.rs_pending, 1'b0);
        chk("md_rt_pend_r3", bus.rt_pending, 1'b1);
        chk("md_commit_addr3", bus.commit_addr, 5'd3);
        clear_wr();
        reset = 1'b0;
        #1;
        chk("md_async_commit_valid", bus.commit_valid, 1'b0);
        chk("md_async_wr_ready", bus.wr_ready, 4'h0);
        chk("md_async_rs_data", bus.rs_data, 32'h0);
        tick();
        reset = 1'b1;
        tick();
        chk("md_r1_zeroed", bus.rs_data, 32'h0);
        chk("md_r3_discarded", bus.rt_data, 32'h0);
        chk("md_r3_pending", bus.rt_pending, 1'b0);
        chk("md_wr_ready", bus.wr_ready, 4'hF);
        chk("md_commit_idle", bus.commit_valid, 1'b0);

        // same-edge bypass on port 1
        set_rd(1'b0, 5'd5, 1'b0, 5'd5);
        set_wr(1, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF);
        tick();
        chk("bp_pending_after_accept", bus.rs_pending, 1'b1);
        chk("bp_data_before_commit", bus.rs_data, 32'h0);
        chk("bp_commit_port", bus.commit_port, 3'd1);
        clear_wr();
        tick();
        chk("bp_commit_edge_data", bus.rs_data, 32'hDEADBEEF);
        chk("bp_commit_edge_pending", bus.rs_pending, 1'b0);
        chk("bp_idle", bus.commit_valid, 1'b0);
        tick();
        chk("bp_bank_data", bus.rt_data, 32'hDEADBEEF);

        // int r7 vs float r7 (pointer now at 2)
        set_rd(1'b0, 5'd7, 1'b1, 5'd7);
        set_wr(0, 1'b1, 1'b0, 5'd7, 32'h11111111);
        set_wr(2, 1'b1, 1'b1, 5'd7, 32'h22222222);
        tick();
        chk("sep_rs_pending", bus.rs_pending, 1'b1);
        chk("sep_rt_pending", bus.rt_pending, 1'b1);
        chk("sep_first_port", bus.commit_port, 3'd2);
        clear_wr();
        tick();
        chk("sep_rt_bypass", bus.rt_data, 32'h22222222);
        chk("sep_rt_pend_clear", bus.rt_pending, 1'b0);
        chk("sep_rs_still_pend", bus.rs_pending, 1'b1);
        chk("sep_rs_still_old", bus.rs_data, 32'h0);
        chk("sep_second_port", bus.commit_port, 3'd0);
        tick();
        chk("sep_rs_bypass", bus.rs_data, 32'h11111111);
        chk("sep_rs_pend_clear", bus.rs_pending, 1'b0);
        tick();
        chk("sep_rs_int_r7", bus.rs_data, 32'h11111111);
        chk("sep_rt_flt_r7", bus.rt_data, 32'h22222222);

        // round-robin over 4 saturated ports, 2 entries each
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int p = 0; p < NW; p++) set_wr(p, 1'b1, 1'b0, AW'(10 + p), DW'(p * 16));
        tick();
        chk("rr_ready_first", bus.wr_ready, 4'hF);
        chk("rr_port0", bus.commit_port, 3'd0);
        chk("rr_data0", bus.commit_data, 32'h0);
        for (int p = 0; p < NW; p++) set_wr(p, 1'b1, 1'b0, AW'(10 + p), DW'(p * 16 + 1));
        tick();
        clear_wr();
        chk("rr_ready_full", bus.wr_ready, 4'b0001);
        chk("rr_port1", bus.commit_port, 3'd1);
        chk("rr_data1", bus.commit_data, 32'h10);
        for (int j = 2; j < 8; j++) begin
            tick();
            chk($sformatf("rr_port%0d", j), bus.commit_port, 3'(j % 4));
            chk($sformatf("rr_data%0d", j), bus.commit_data, DW'((j % 4) * 16 + j / 4));
        end
        tick();
        chk("rr_drained", bus.commit_valid, 1'b0);

        // back-pressure on port 2 while 0,1,3 stay saturated
        p2_exp[0] = 32'hA;
        p2_exp[1] = 32'hB;
        p2_exp[2] = 32'hC;
        k2 = 0; pushes = 0; commits = 0; cyc = 0; bp_seen = 1'b0;
        set_rd(1'b1, 5'd9, 1'b0, 5'd0);
        set_wr(0, 1'b1, 1'b0, 5'd20, 32'h100);
        set_wr(1, 1'b1, 1'b0, 5'd21, 32'h101);
        set_wr(3, 1'b1, 1'b0, 5'd23, 32'h103);
        set_wr(2, 1'b1, 1'b1, 5'd9, p2_exp[0]);
        while (k2 < 3 && cyc < 100) begin
            rdy = bus.wr_ready;
            val = bus.wr_valid;
            if (bus.commit_valid) begin
                commits++;
                if (bus.commit_port == 3'd2) p2_log.push_back(bus.commit_data);
            end
            pushes += $countones(rdy & val);
            if (!rdy[2]) bp_seen = 1'b1;
            tick();
            cyc++;
            if (rdy[2] && val[2]) begin
                k2++;
                if (k2 < 3) set_wr(2, 1'b1, 1'b1, 5'd9, p2_exp[k2]);
                else set_wr(2, 1'b0, 1'b0, 5'd0, 32'h0);
            end
        end
        clear_wr();
        while (bus.commit_valid && cyc < 100) begin
            commits++;
            if (bus.commit_port == 3'd2) p2_log.push_back(bus.commit_data);
            tick();
            cyc++;
        end
        chk("bkp_within_budget", (cyc < 100), 1'b1);
        chk("bkp_ready2_dropped", bp_seen, 1'b1);
        chk("bkp_no_loss_or_dup", commits, pushes);
        chk("bkp_p2_count", p2_log.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bkp_p2_order%0d", i), (i < p2_log.size()) ? p2_log[i] : 32'hX, p2_exp[i]);
        end
        tick();
        chk("bkp_flt_r9", bus.rs_data, 32'hC);
        chk("bkp_flt_r9_pend", bus.rs_pending, 1'b0);

        // int r0 / float r0
        set_rd(1'b0, 5'd0, 1'b1, 5'd0);
        set_wr(3, 1'b1, 1'b0, 5'd0, 32'h5);
        set_wr(1, 1'b1, 1'b1, 5'd0, 32'h6);
        tick();
        clear_wr();
        chk("z_int_r0_pending", bus.rs_pending, ZR ? 1'b0 : 1'b1);
        chk("z_flt_r0_pending", bus.rt_pending, 1'b1);
        chk("z_commit_valid", bus.commit_valid, 1'b1);
        chk("z_commit_addr", bus.commit_addr, 5'd0);
        repeat (2) tick();
        chk("z_drained", bus.commit_valid, 1'b0);
        tick();
        chk("z_int_r0_data", bus.rs_data, ZR ? 32'h0 : 32'h5);
        chk("z_flt_r0_data", bus.rt_data, 32'h6);
        chk("z_int_r0_pend_end", bus.rs_pending, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
